// File: rtl/aurora_tx_framer_if.sv
// Stream bundle between the payload source, the framer and the Aurora TX port.
// master: framer side (drives axiTX* and payloadReady); slave: environment side.
interface aurora_tx_framer_if;
  logic [63:0] payloadData;
  logic        payloadValid;
  logic        payloadReady;
  logic [63:0] axiTXtdata;
  logic [7:0]  axiTXtkeep;
  logic        axiTXtvalid;
  logic        axiTXtlast;
  logic        axiTXtready;

  modport master (
    input  payloadData,
    input  payloadValid,
    input  axiTXtready,
    output payloadReady,
    output axiTXtdata,
    output axiTXtkeep,
    output axiTXtvalid,
    output axiTXtlast
  );

  modport slave (
    output payloadData,
    output payloadValid,
    output axiTXtready,
    input  payloadReady,
    input  axiTXtdata,
    input  axiTXtkeep,
    input  axiTXtvalid,
    input  axiTXtlast
  );
endinterface

// File: rtl/aurora_tx_framer.sv
// Aurora 64b66b TX framer: one header beat then frameWords payload beats.
// Ports: userClk/userReset_n, channelUP, start request, tx stream bundle, status.
module aurora_tx_framer #(
  parameter logic [15:0] MAGIC         = 16'hA5C3,
  parameter int          NODE_ID_WIDTH = 8,
  parameter int          COUNT_WIDTH   = 16
) (
  input  logic                     userClk,
  input  logic                     userReset_n,
  input  logic                     channelUP,
  input  logic [NODE_ID_WIDTH-1:0] nodeId,
  input  logic                     frameStart,
  input  logic [15:0]              frameWords,
  aurora_tx_framer_if.master       tx,
  output logic                     busy,
  output logic [15:0]              seqNum,
  output logic [COUNT_WIDTH-1:0]   startDropCount,
  output logic [COUNT_WIDTH-1:0]   abortCount
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            rem_q, rem_d;
  logic [63:0]            hdr_q, hdr_d;
  logic [15:0]            seq_q, seq_d;
  logic [COUNT_WIDTH-1:0] drop_q, drop_d;
  logic [COUNT_WIDTH-1:0] abort_q, abort_d;

  logic beat;
  logic abort_inc;

  assign beat = tx.payloadValid & tx.axiTXtready;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    hdr_d     = hdr_q;
    seq_d     = seq_q;
    drop_d    = drop_q;
    abort_d   = abort_q;
    abort_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frameStart) begin
          if (channelUP && frameWords != 16'd0) begin
            state_d = HEADER;
            rem_d   = frameWords;
            hdr_d   = {MAGIC, 16'(nodeId), seq_q, frameWords};
          end else if (drop_q != '1) begin
            drop_d = drop_q + COUNT_WIDTH'(1);
          end
        end
      end
      HEADER: begin
        // tvalid is always high here, so tready alone is the handshake
        if (tx.axiTXtready) begin
          seq_d   = seq_q + 16'd1;
          state_d = PAYLOAD;
        end else if (!channelUP) begin
          state_d   = DRAIN;
          abort_inc = 1'b1;
        end
      end
      PAYLOAD: begin
        if (beat) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = IDLE;
          end else if (!channelUP) begin
            state_d   = DRAIN;
            abort_inc = 1'b1;
          end
        end else if (!channelUP) begin
          state_d   = DRAIN;
          abort_inc = 1'b1;
        end
      end
      DRAIN: begin
        // swallow the rest of the upstream frame to keep it aligned
        if (rem_q == 16'd0) begin
          state_d = IDLE;
        end else if (tx.payloadValid) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_inc && abort_q != '1) abort_d = abort_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge userClk) begin
    if (!userReset_n) begin
      state_q <= IDLE;
      rem_q   <= 16'd0;
      hdr_q   <= 64'd0;
      seq_q   <= 16'd0;
      drop_q  <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      abort_q <= abort_d;
    end
  end

  // payload phase is a zero-latency pass-through of the upstream stream
  always_comb begin
    tx.axiTXtkeep   = 8'hFF;
    tx.axiTXtvalid  = 1'b0;
    tx.axiTXtlast   = 1'b0;
    tx.axiTXtdata   = 64'd0;
    tx.payloadReady = 1'b0;
    unique case (state_q)
      IDLE: ;
      HEADER: begin
        tx.axiTXtvalid = 1'b1;
        tx.axiTXtdata  = hdr_q;
      end
      PAYLOAD: begin
        tx.axiTXtvalid  = tx.payloadValid;
        tx.axiTXtdata   = tx.payloadData;
        tx.payloadReady = tx.axiTXtready;
        tx.axiTXtlast   = (rem_q == 16'd1);
      end
      DRAIN: tx.payloadReady = 1'b1;
      default: ;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign seqNum         = seq_q;
  assign startDropCount = drop_q;
  assign abortCount     = abort_q;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Directed self-checking bench for aurora_tx_framer.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_aurora_tx_framer;

  logic        userClk;
  logic        userReset_n;
  logic        channelUP;
  logic [7:0]  nodeId;
  logic        frameStart;
  logic [15:0] frameWords;
  logic        busy;
  logic [15:0] seqNum;
  logic [15:0] startDropCount;
  logic [15:0] abortCount;

  int n_ok;
  int n_chk;

  aurora_tx_framer_if bus ();

  aurora_tx_framer dut (
    .userClk        (userClk),
    .userReset_n    (userReset_n),
    .channelUP      (channelUP),
    .nodeId         (nodeId),
    .frameStart     (frameStart),
    .frameWords     (frameWords),
    .tx             (bus.master),
    .busy           (busy),
    .seqNum         (seqNum),
    .startDropCount (startDropCount),
    .abortCount     (abortCount)
  );

  initial userClk = 1'b0;
  always #5 userClk = ~userClk;

  task automatic tick();
    @(posedge userClk);
    #1;
  endtask

  task automatic test_reset();
    userReset_n = 1'b0;
    tick();
    tick();
    userReset_n = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else n_ok++;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0 || bus.payloadReady !== 1'b0)
      $display("FAIL rst_hs got v=%b r=%b want 0 0",
               bus.axiTXtvalid, bus.payloadReady);
    else n_ok++;
    n_chk++;
    if (bus.axiTXtdata !== 64'd0) $display("FAIL rst_data got %h want 0", bus.axiTXtdata);
    else n_ok++;
    n_chk++;
    if (seqNum !== 16'd0 || startDropCount !== 16'd0 || abortCount !== 16'd0)
      $display("FAIL rst_cnt got %h %h %h want 0 0 0",
               seqNum, startDropCount, abortCount);
    else n_ok++;
  endtask

  task automatic test_basic();
    logic [63:0] exp [4];
    exp[0] = 64'hA5C3_0012_0000_0003;
    exp[1] = 64'd1;
    exp[2] = 64'd2;
    exp[3] = 64'd3;
    channelUP = 1'b1;
    nodeId = 8'h12;
    bus.axiTXtready = 1'b1;
    frameStart = 1'b1;
    frameWords = 16'd3;
    tick();
    frameStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.payloadValid = 1'b1;
      bus.payloadData = exp[i];
      #1;
      n_chk++;
      if (bus.axiTXtvalid !== 1'b1 || bus.axiTXtdata !== exp[i])
        $display("FAIL basic_beat%0d got v=%b d=%h want v=1 d=%h",
                 i, bus.axiTXtvalid, bus.axiTXtdata, exp[i]);
      else n_ok++;
      n_chk++;
      if (bus.axiTXtlast !== (i == 3) || bus.axiTXtkeep !== 8'hFF)
        $display("FAIL basic_last%0d got l=%b k=%h want l=%b k=ff",
                 i, bus.axiTXtlast, bus.axiTXtkeep, (i == 3));
      else n_ok++;
      tick();
    end
    bus.payloadValid = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || seqNum !== 16'd1 || bus.axiTXtvalid !== 1'b0)
      $display("FAIL basic_end got busy=%b seq=%h v=%b want 0 0001 0",
               busy, seqNum, bus.axiTXtvalid);
    else n_ok++;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp [4];
    logic        pat [4];
    logic [63:0] held_d;
    logic        held;
    int          beats;
    int          pi;
    int          cyc;
    exp[0] = 64'hA5C3_0012_0001_0003;
    exp[1] = 64'hB1;
    exp[2] = 64'hB2;
    exp[3] = 64'hB3;
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;
    held = 1'b0;
    held_d = 64'd0;
    beats = 0;
    pi = 1;
    cyc = 0;
    bus.axiTXtready = 1'b0;
    frameStart = 1'b1;
    frameWords = 16'd3;
    tick();
    frameStart = 1'b0;
    while (beats < 4 && cyc < 40) begin
      bus.axiTXtready = pat[cyc % 4];
      bus.payloadValid = 1'b1;
      bus.payloadData = exp[pi];
      #1;
      if (bus.axiTXtvalid) begin
        if (held) begin
          n_chk++;
          if (bus.axiTXtdata !== held_d)
            $display("FAIL bp_stable got %h want %h", bus.axiTXtdata, held_d);
          else n_ok++;
        end
        if (beats >= 1) begin
          n_chk++;
          if (bus.payloadReady !== bus.axiTXtready)
            $display("FAIL bp_ready got %b want %b",
                     bus.payloadReady, bus.axiTXtready);
          else n_ok++;
        end
        if (bus.axiTXtready) begin
          n_chk++;
          if (bus.axiTXtdata !== exp[beats] || bus.axiTXtlast !== (beats == 3))
            $display("FAIL bp_beat%0d got d=%h l=%b want d=%h l=%b", beats,
                     bus.axiTXtdata, bus.axiTXtlast, exp[beats], (beats == 3));
          else n_ok++;
          if (beats >= 1 && pi < 3) pi++;
          beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_d = bus.axiTXtdata;
        end
      end
      tick();
      cyc++;
    end
    bus.payloadValid = 1'b0;
    bus.axiTXtready = 1'b1;
    #1;
    n_chk++;
    if (beats !== 4) $display("FAIL bp_count got %0d want 4", beats);
    else n_ok++;
    n_chk++;
    if (busy !== 1'b0 || seqNum !== 16'd2 || bus.axiTXtvalid !== 1'b0)
      $display("FAIL bp_end got busy=%b seq=%h v=%b want 0 0002 0",
               busy, seqNum, bus.axiTXtvalid);
    else n_ok++;
  endtask

  task automatic test_rejected();
    frameStart = 1'b1;
    frameWords = 16'd0;
    channelUP = 1'b1;
    #1;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0) $display("FAIL rej_v0 got %b want 0", bus.axiTXtvalid);
    else n_ok++;
    tick();
    frameWords = 16'd3;
    channelUP = 1'b0;
    #1;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rej_v1 got v=%b busy=%b want 0 0", bus.axiTXtvalid, busy);
    else n_ok++;
    tick();
    frameStart = 1'b0;
    channelUP = 1'b1;
    #1;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rej_v2 got v=%b busy=%b want 0 0", bus.axiTXtvalid, busy);
    else n_ok++;
    n_chk++;
    if (startDropCount !== 16'd2 || seqNum !== 16'd2)
      $display("FAIL rej_cnt got drop=%0d seq=%h want 2 0002",
               startDropCount, seqNum);
    else n_ok++;
  endtask

  task automatic test_link_loss();
    channelUP = 1'b1;
    bus.axiTXtready = 1'b1;
    bus.payloadValid = 1'b0;
    frameStart = 1'b1;
    frameWords = 16'd5;
    tick();
    frameStart = 1'b0;
    #1;
    n_chk++;
    if (bus.axiTXtdata !== 64'hA5C3_0012_0002_0005)
      $display("FAIL ll_hdr got %h want a5c3001200020005", bus.axiTXtdata);
    else n_ok++;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.payloadValid = 1'b1;
      bus.payloadData = 64'h11 + 64'(i);
      tick();
    end
    bus.payloadValid = 1'b0;
    channelUP = 1'b0;
    tick();
    #1;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0 || bus.payloadReady !== 1'b1)
      $display("FAIL ll_drain got v=%b r=%b want 0 1",
               bus.axiTXtvalid, bus.payloadReady);
    else n_ok++;
    n_chk++;
    if (abortCount !== 16'd1) $display("FAIL ll_abort got %0d want 1", abortCount);
    else n_ok++;
    bus.payloadValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (busy !== 1'b1 || bus.axiTXtvalid !== 1'b0)
        $display("FAIL ll_busy%0d got busy=%b v=%b want 1 0",
                 i, busy, bus.axiTXtvalid);
      else n_ok++;
      tick();
    end
    bus.payloadValid = 1'b0;
    channelUP = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || seqNum !== 16'd3 || abortCount !== 16'd1)
      $display("FAIL ll_end got busy=%b seq=%h abort=%0d want 0 0003 1",
               busy, seqNum, abortCount);
    else n_ok++;
  endtask

  task automatic test_seq_wrap();
    force dut.seq_q = 16'hFFFF;
    tick();
    release dut.seq_q;
    frameStart = 1'b1;
    frameWords = 16'd1;
    bus.axiTXtready = 1'b1;
    tick();
    frameStart = 1'b0;
    #1;
    n_chk++;
    if (bus.axiTXtdata !== 64'hA5C3_0012_FFFF_0001)
      $display("FAIL wrap_hdr got %h want a5c30012ffff0001", bus.axiTXtdata);
    else n_ok++;
    tick();
    bus.payloadValid = 1'b1;
    bus.payloadData = 64'hDEAD;
    #1;
    n_chk++;
    if (bus.axiTXtlast !== 1'b1 || bus.axiTXtdata !== 64'hDEAD)
      $display("FAIL wrap_last got l=%b d=%h want 1 dead",
               bus.axiTXtlast, bus.axiTXtdata);
    else n_ok++;
    tick();
    bus.payloadValid = 1'b0;
    #1;
    n_chk++;
    if (seqNum !== 16'h0000 || busy !== 1'b0)
      $display("FAIL wrap_seq got seq=%h busy=%b want 0000 0", seqNum, busy);
    else n_ok++;
  endtask

  task automatic test_reset_mid();
    frameStart = 1'b1;
    frameWords = 16'd4;
    bus.axiTXtready = 1'b1;
    tick();
    frameStart = 1'b0;
    tick();
    bus.payloadValid = 1'b1;
    bus.payloadData = 64'h77;
    tick();
    userReset_n = 1'b0;
    tick();
    #1;
    n_chk++;
    if (bus.axiTXtvalid !== 1'b0 || bus.payloadReady !== 1'b0 || busy !== 1'b0)
      $display("FAIL rmid_hs got v=%b r=%b busy=%b want 0 0 0",
               bus.axiTXtvalid, bus.payloadReady, busy);
    else n_ok++;
    n_chk++;
    if (seqNum !== 16'd0 || startDropCount !== 16'd0 || abortCount !== 16'd0)
      $display("FAIL rmid_cnt got %h %h %h want 0 0 0",
               seqNum, startDropCount, abortCount);
    else n_ok++;
    userReset_n = 1'b1;
    bus.payloadValid = 1'b0;
    tick();
  endtask

  initial begin
    n_ok = 0;
    n_chk = 0;
    userReset_n = 1'b0;
    channelUP = 1'b0;
    nodeId = 8'h12;
    frameStart = 1'b0;
    frameWords = 16'd0;
    bus.payloadData = 64'd0;
    bus.payloadValid = 1'b0;
    bus.axiTXtready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_rejected();
    test_link_loss();
    test_seq_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/aurora_tx_framer.md
Name: aurora_tx_framer

Overview:
- TX-side frame builder that drives the Aurora 64b66b TX AXI4-Stream input (axiTX*) of the MGT wrapper in the userClk domain.
- On a start request it does two things: emits a single header word carrying magic, node ID, sequence number and word count; then streams the requested number of payload words from an upstream source with full backpressure.
- Handles link loss mid-frame by discarding the remainder of the frame and counting the event.

Parameters:
- MAGIC, 16'hA5C3, header word bits [63:48].
- NODE_ID_WIDTH, 8, width of nodeId input (≤ 16).
- COUNT_WIDTH, 16, width of the status/error counters.

Ports:
- userClk  input  1  Aurora user clock; all logic is on its rising edge.
- userReset_n  input  1  synchronous active-low reset.
- channelUP  input  1  Aurora channel_up, already in the userClk domain.
- nodeId  input  NODE_ID_WIDTH  node ID for the header; sampled on an accepted start.
- frameStart  input  1  single-cycle start request.
- frameWords  input  16  payload length in 64-bit words; sampled with frameStart.
- payloadData  input  64  upstream payload word.
- payloadValid  input  1  upstream valid.
- payloadReady  output  1  upstream ready.
- axiTXtdata  output  64  to the Aurora TX stream.
- axiTXtkeep  output  8  always 8'hFF.
- axiTXtvalid  output  1
- axiTXtlast  output  1
- axiTXtready  input  1
- busy  output  1  high in any state other than IDLE.
- seqNum  output  16  sequence number of the next frame.
- startDropCount  output  COUNT_WIDTH  count of starts that were rejected.
- abortCount  output  COUNT_WIDTH  count of frames truncated by link loss.

Behaviour:
- Reset (userReset_n=0 at a clock edge):
  - state goes to IDLE.
  - seqNum=0, startDropCount=0, abortCount=0.
  - axiTXtvalid=0, axiTXtlast=0, payloadReady=0, busy=0, axiTXtdata=0.
  - Reset wins over every other event, including mid-frame. A frame interrupted by reset is not counted as an abort.
- IDLE:
  - Outputs: axiTXtvalid=0, payloadReady=0.
  - A start is accepted only when frameStart=1, channelUP=1 and frameWords≠0. On acceptance, in the next cycle:
    - latch frameWords into remaining.
    - latch the header {MAGIC, 8'h00 padded nodeId to 16 bits in [47:32], seqNum[31:16], frameWords[15:0]}.
    - go to HEADER.
  - frameStart with channelUP=0 or frameWords=0: startDropCount++ (saturating); state stays IDLE.
- HEADER:
  - axiTXtvalid=1, axiTXtdata=header, axiTXtlast=0; header held stable until the handshake.
  - On axiTXtvalid&axiTXtready: seqNum++ (16-bit wrap, FFFF→0000), then go to PAYLOAD.
  - If channelUP=0 before the handshake: go to DRAIN and abortCount++. seqNum is not incremented.
- PAYLOAD (combinational pass-through):
  - axiTXtvalid=payloadValid, axiTXtdata=payloadData, payloadReady=axiTXtready.
  - axiTXtlast = (remaining==1).
  - Each beat with payloadValid&axiTXtready decrements remaining.
  - The beat with remaining==1 completes the frame and returns to IDLE. The frame is exactly frameWords payload beats plus 1 header beat.
  - If channelUP=0 in a cycle with no completing handshake: go to DRAIN and abortCount++ (saturating). A handshake completing in the same cycle as the channel drop is honoured first.
- DRAIN:
  - axiTXtvalid=0, payloadReady=1.
  - Consumes and discards the remaining upstream words; each payloadValid decrements remaining.
  - At remaining==0 (or on entry with remaining==0): go to IDLE.
  - Keeps upstream frame alignment intact.
- Ignored starts:
  - frameStart while busy is ignored and not counted (the upstream scheduler owns pacing).
  - frameStart in the same cycle as frame completion is ignored.
- Counters saturate at all-ones.
- Latency: header valid 1 cycle after an accepted frameStart. Payload adds zero latency (combinational).
- Stability: axiTXtvalid is never withdrawn without a handshake, except on channel loss, where Aurora ignores the stream.

Test Plan:
- Basic frame: reset, channelUP=1, nodeId=8'h12, frameStart with frameWords=3, payload 0x1,0x2,0x3, tready=1.
  - Expect beats A5C3_0012_0000_0003, 1, 2, 3; tlast only on the 3rd payload beat; tkeep=FF; seqNum=1 after.
- Backpressure: same frame with tready toggling 1-0-0-1…
  - Header and data are held stable while tready=0; payloadReady mirrors tready; exactly 4 beats total.
- Rejected starts: frameWords=0, and separately channelUP=0.
  - No tvalid; startDropCount=2; seqNum unchanged.
- Link loss mid-frame: frameWords=5; drop channelUP after 2 payload beats.
  - tvalid=0 from the next cycle; remaining 3 upstream words consumed with payloadReady=1; abortCount=1; busy falls after the 3rd discarded word.
- Sequence wrap: preload via 65535 frames (or force seqNum=FFFF).
  - Header [31:16]=FFFF; seqNum=0000 afterwards.
- Reset mid-PAYLOAD: assert userReset_n=0.
  - Next cycle: tvalid=0, payloadReady=0, busy=0, all counters 0.
